// File: rtl/sobel_y_scan_ctrl.sv
// ============================================================================
//  Module   : sobel_y_scan_ctrl
//  Summary  : Column-major frame-scan sequencer and result-tag pipeline for
//             the streaming Sobel-Y datapath.
//  Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module sobel_y_scan_ctrl #(
   parameter int IMG_W   = 640,
   parameter int IMG_H   = 480,
   parameter int ADDR_W  = 19,
   parameter int MEM_LAT = 1,
   parameter int DP_LAT  = 5
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start_i,
   input  logic                      abort_i,
   output logic                      busy_o,
   output logic                      done_o,
   output logic                      rd_en_o,
   output logic [ADDR_W-1:0]         rd_addr_l_o,
   output logic [ADDR_W-1:0]         rd_addr_c_o,
   output logic [ADDR_W-1:0]         rd_addr_r_o,
   output logic                      out_valid_o,
   output logic [$clog2(IMG_W)-1:0]  out_x_o,
   output logic [$clog2(IMG_H)-1:0]  out_y_o,
   output logic                      out_last_o
);

   localparam int XW    = $clog2(IMG_W);
   localparam int YW    = $clog2(IMG_H);
   localparam int TAG_D = MEM_LAT + DP_LAT;
   localparam int CW    = $clog2(TAG_D + 1);

   localparam logic [XW-1:0]     X_MAX      = XW'(IMG_W - 1);
   localparam logic [YW-1:0]     Y_MAX      = YW'(IMG_H - 1);
   localparam logic [ADDR_W-1:0] ROW_STEP   = ADDR_W'(IMG_W);
   localparam logic [ADDR_W-1:0] ADDR_ONE   = ADDR_W'(1);
   localparam logic [CW-1:0]     DRAIN_INIT = CW'(TAG_D - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t              state_q;
   logic [XW-1:0]       x_q, x_d;
   logic [YW-1:0]       y_q, y_d;
   logic [ADDR_W-1:0]   addr_c_q, addr_c_d;
   logic [ADDR_W-1:0]   addr_l_q, addr_l_d;
   logic [ADDR_W-1:0]   addr_r_q, addr_r_d;
   logic [CW-1:0]       drain_q;
   logic                busy_q, done_q, rd_en_q;
   logic                last_pix;

   logic                tag_v_d, tag_l_d;
   logic [XW-1:0]       tag_x_d;
   logic [YW-1:0]       tag_y_d;

   assign last_pix = (x_q == X_MAX) && (y_q == Y_MAX);

   // Next pixel in column-major order; the address walks down a column by
   // adding one row stride and reloads to the column index at each wrap.
   always_comb begin
      x_d      = x_q;
      y_d      = y_q + YW'(1);
      addr_c_d = addr_c_q + ROW_STEP;
      if (y_q == Y_MAX) begin
         x_d      = x_q + XW'(1);
         y_d      = '0;
         addr_c_d = ADDR_W'(x_d);
      end
      addr_l_d = (x_d == '0)    ? addr_c_d : addr_c_d - ADDR_ONE;
      addr_r_d = (x_d == X_MAX) ? addr_c_d : addr_c_d + ADDR_ONE;
   end

   always_ff @(posedge clk) begin
      if (rst || abort_i) begin
         state_q  <= S_IDLE;
         x_q      <= '0;
         y_q      <= '0;
         addr_c_q <= '0;
         addr_l_q <= '0;
         addr_r_q <= '0;
         drain_q  <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         rd_en_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start_i) begin
                  state_q  <= S_RUN;
                  busy_q   <= 1'b1;
                  rd_en_q  <= 1'b1;
                  x_q      <= '0;
                  y_q      <= '0;
                  addr_c_q <= '0;
                  addr_l_q <= '0;
                  addr_r_q <= ADDR_ONE;
               end
            end
            S_RUN: begin
               if (last_pix) begin
                  state_q  <= S_DRAIN;
                  rd_en_q  <= 1'b0;
                  x_q      <= '0;
                  y_q      <= '0;
                  addr_c_q <= '0;
                  addr_l_q <= '0;
                  addr_r_q <= '0;
                  drain_q  <= DRAIN_INIT;
               end else begin
                  x_q      <= x_d;
                  y_q      <= y_d;
                  addr_c_q <= addr_c_d;
                  addr_l_q <= addr_l_d;
                  addr_r_q <= addr_r_d;
               end
            end
            S_DRAIN: begin
               if (drain_q == '0) begin
                  state_q <= S_DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end else begin
                  drain_q <= drain_q - 1'b1;
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   // Rows 0 and 1 of each column mix in the previous column, so only y >= 2
   // yields a real result, reported against the centre row y-1.
   assign tag_v_d = rd_en_q && (y_q >= YW'(2));
   assign tag_l_d = tag_v_d && last_pix;
   assign tag_x_d = rd_en_q ? x_q : '0;
   assign tag_y_d = rd_en_q ? (y_q - YW'(1)) : '0;

   for (genvar i = 0; i < TAG_D; i++) begin : g_tag
      logic          v_q, l_q;
      logic [XW-1:0] x_q;
      logic [YW-1:0] y_q;

      if (i == 0) begin : g_head
         always_ff @(posedge clk) begin
            if (rst || abort_i) begin
               v_q <= 1'b0;
               l_q <= 1'b0;
               x_q <= '0;
               y_q <= '0;
            end else begin
               v_q <= tag_v_d;
               l_q <= tag_l_d;
               x_q <= tag_x_d;
               y_q <= tag_y_d;
            end
         end
      end else begin : g_body
         always_ff @(posedge clk) begin
            if (rst || abort_i) begin
               v_q <= 1'b0;
               l_q <= 1'b0;
               x_q <= '0;
               y_q <= '0;
            end else begin
               v_q <= g_tag[i-1].v_q;
               l_q <= g_tag[i-1].l_q;
               x_q <= g_tag[i-1].x_q;
               y_q <= g_tag[i-1].y_q;
            end
         end
      end
   end

   assign busy_o      = busy_q;
   assign done_o      = done_q;
   assign rd_en_o     = rd_en_q;
   assign rd_addr_l_o = addr_l_q;
   assign rd_addr_c_o = addr_c_q;
   assign rd_addr_r_o = addr_r_q;
   assign out_valid_o = g_tag[TAG_D-1].v_q;
   assign out_last_o  = g_tag[TAG_D-1].l_q;
   assign out_x_o     = g_tag[TAG_D-1].x_q;
   assign out_y_o     = g_tag[TAG_D-1].y_q;

endmodule

`default_nettype wire

// File: tb/tb_sobel_y_scan_ctrl.sv
// ============================================================================
//  Module   : tb_sobel_y_scan_ctrl
//  Summary  : Directed bench for sobel_y_scan_ctrl with a 1-cycle RAM and a
//             Sobel-Y datapath model feeding a result scoreboard.
//  Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_sobel_y_scan_ctrl;

   localparam int W  = 4;
   localparam int H  = 4;
   localparam int AW = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic          busy, done, rd_en, out_valid, out_last;
   logic [AW-1:0] rd_addr_l, rd_addr_c, rd_addr_r;
   logic [1:0]    out_x, out_y;

   always #5 clk = ~clk;

   sobel_y_scan_ctrl #(
      .IMG_W(W), .IMG_H(H), .ADDR_W(AW), .MEM_LAT(1), .DP_LAT(5)
   ) dut (
      .clk(clk), .rst(rst), .start_i(start), .abort_i(abort),
      .busy_o(busy), .done_o(done), .rd_en_o(rd_en),
      .rd_addr_l_o(rd_addr_l), .rd_addr_c_o(rd_addr_c), .rd_addr_r_o(rd_addr_r),
      .out_valid_o(out_valid), .out_x_o(out_x), .out_y_o(out_y),
      .out_last_o(out_last)
   );

   int mem [16];
   int ml, mc, mr, h0, h1, h2, d1, d2, d3, d4;

   // Frame buffer (1-cycle read) and 5-cycle Sobel-Y datapath:
   // h = l + 2c + r per row, result = h(row y) - h(row y-2).
   always @(posedge clk) begin
      if (rd_en) begin
         ml <= mem[rd_addr_l];
         mc <= mem[rd_addr_c];
         mr <= mem[rd_addr_r];
      end
      h0 <= ml + 2 * mc + mr;
      h1 <= h0;
      h2 <= h1;
      d1 <= h0 - h2;
      d2 <= d1;
      d3 <= d2;
      d4 <= d3;
   end

   typedef struct packed {
      int x;
      int y;
      int last;
      int data;
   } exp_t;

   exp_t sbq [$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;
   int   nvalid = 0;

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (out_valid) begin
         nvalid++;
         if (sbq.size() == 0) begin
            check("unexpected_valid", 1, 0);
         end else begin
            mon_e = sbq.pop_front();
            check("out_x", int'(out_x), mon_e.x);
            check("out_y", int'(out_y), mon_e.y);
            check("out_last", int'(out_last), mon_e.last);
            check("sobel_data", d4, mon_e.data);
         end
      end
   end

   task automatic push_results(input int ncols, input int dval);
      for (int x = 0; x < ncols; x++)
         for (int y = 1; y <= H - 2; y++)
            sbq.push_back('{x, y, int'(x == W - 1 && y == H - 2), dval});
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_busy"}, int'(busy), 0);
      check({tag, "_done"}, int'(done), 0);
      check({tag, "_rd_en"}, int'(rd_en), 0);
      check({tag, "_out_valid"}, int'(out_valid), 0);
      check({tag, "_out_last"}, int'(out_last), 0);
      check({tag, "_addr_l"}, int'(rd_addr_l), 0);
      check({tag, "_addr_c"}, int'(rd_addr_c), 0);
      check({tag, "_addr_r"}, int'(rd_addr_r), 0);
      check({tag, "_out_x"}, int'(out_x), 0);
      check({tag, "_out_y"}, int'(out_y), 0);
   endtask

   // Full 4x4 frame with cycle-exact checks; cycle 0 is the start cycle.
   task automatic run_frame(input int dval, input bit poke);
      int n0, idx, px, py, ev;
      n0 = nvalid;
      push_results(W, dval);
      @(posedge clk); #1; start = 1'b1;
      for (int c = 1; c <= 30; c++) begin
         @(posedge clk); #1;
         start = poke && (c == 3 || c == 10);
         check("rd_en", int'(rd_en), int'(c <= 16));
         if (c <= 16) begin
            idx = c - 1;
            px  = idx / H;
            py  = idx % H;
            check("addr_c", int'(rd_addr_c), py * W + px);
            check("addr_l", int'(rd_addr_l), py * W + ((px == 0) ? 0 : px - 1));
            check("addr_r", int'(rd_addr_r), py * W + ((px == W - 1) ? px : px + 1));
         end
         check("busy", int'(busy), int'(c <= 22));
         check("done", int'(done), int'(c == 23));
         ev = int'(c >= 7 && c <= 22 && ((c - 7) % H) >= 2);
         check("valid_timing", int'(out_valid), ev);
         check("last_timing", int'(out_last), int'(c == 22));
      end
      start = 1'b0;
      check("frame_results", nvalid - n0, W * (H - 2));
      check("sb_empty", sbq.size(), 0);
   endtask

   initial begin
      for (int a = 0; a < 16; a++) mem[a] = 100;

      repeat (3) @(posedge clk);
      #1;
      check_all_zero("reset");
      rst = 1'b0;

      run_frame(0, 1'b0);

      for (int a = 0; a < 16; a++) mem[a] = 10 * (a / W);
      run_frame(80, 1'b1);

      // start and abort together while idle
      @(posedge clk); #1; start = 1'b1; abort = 1'b1;
      for (int c = 1; c <= 4; c++) begin
         @(posedge clk); #1;
         start = 1'b0;
         abort = 1'b0;
         check("idle_sa_busy", int'(busy), 0);
         check("idle_sa_rd_en", int'(rd_en), 0);
      end

      // abort during RUN at cycle 5
      @(posedge clk); #1; start = 1'b1;
      for (int c = 1; c <= 30; c++) begin
         @(posedge clk); #1;
         start = 1'b0;
         abort = (c == 5);
         check("abort_done", int'(done), 0);
         if (c == 6) check_all_zero("abort");
         if (c >= 6) check("abort_no_valid", int'(out_valid), 0);
      end
      abort = 1'b0;
      check("abort_no_results", sbq.size(), 0);

      run_frame(80, 1'b0);

      // reset during DRAIN: results emerging after cycle 19 are lost
      push_results(W - 1, 80);
      @(posedge clk); #1; start = 1'b1;
      for (int c = 1; c <= 30; c++) begin
         @(posedge clk); #1;
         start = 1'b0;
         rst = (c == 19);
         if (c == 20) check_all_zero("rst_drain");
         if (c >= 20) begin
            check("rst_drain_done", int'(done), 0);
            check("rst_drain_valid", int'(out_valid), 0);
         end
      end
      rst = 1'b0;
      check("rst_drain_sb_empty", sbq.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/sobel_y_scan_ctrl.md
Name: sobel_y_scan_ctrl

Overview:
Frame-scan sequencer for the streaming Sobel-Y datapath (1-2-1 horizontal weights, vertical difference across the stream).
- Walks a stored frame in column-major order and drives three read addresses per cycle (left/current/right neighbours) into a 3-port synchronous frame buffer. The frame buffer's data outputs feed the datapath's left/current/right inputs directly.
- Carries a coordinate/valid tag pipeline matched to memory plus datapath latency, so downstream logic knows which result is real and where it belongs.
- Sits between the frame-buffer writer (start handshake) and the edge-magnitude sink.

Parameters:
- IMG_W, 640, image width in pixels; must be >= 3.
- IMG_H, 480, image height in pixels; must be >= 3.
- ADDR_W, 19, frame-buffer address width; must satisfy 2^ADDR_W >= IMG_W*IMG_H.
- MEM_LAT, 1, frame-buffer read latency in cycles.
- DP_LAT, 5, datapath latency from input sample to registered output.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a frame scan when idle.
- abort  in  1  synchronous abort of the current scan.
- busy  out  1  high from first read issue until the last tag is drained.
- done  out  1  one-cycle pulse after a completed (non-aborted) frame.
- rd_en  out  1  read strobe to the frame buffer.
- rd_addr_l  out  ADDR_W  address of pixel (x-1, y), clamped.
- rd_addr_c  out  ADDR_W  address of pixel (x, y).
- rd_addr_r  out  ADDR_W  address of pixel (x+1, y), clamped.
- out_valid  out  1  the datapath output this cycle is a real result.
- out_x  out  clog2(IMG_W)  column of the current result.
- out_y  out  clog2(IMG_H)  row of the current result (the centre row).
- out_last  out  1  marks the final valid result of the frame.

Behaviour:
- Reset: state IDLE; busy, done, rd_en, out_valid and out_last are 0; all addresses and coordinates are 0; the tag pipeline is cleared.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE -> RUN on start & ~abort.
  - RUN issues one read per cycle for IMG_W*IMG_H cycles, then moves to DRAIN.
  - DRAIN lasts exactly MEM_LAT+DP_LAT cycles, then moves to DONE.
  - DONE lasts one cycle (done=1), then returns to IDLE.
- Scan order: y increments fastest from 0 to IMG_H-1; then x increments. There are no gap cycles between columns.
- Addressing: addr = y*IMG_W + x, produced without a multiplier.
  - rd_addr_c increases by IMG_W each row.
  - At a column wrap, rd_addr_c reloads to the new x.
  - rd_addr_l = rd_addr_c-1 and rd_addr_r = rd_addr_c+1, except: at x=0, rd_addr_l = rd_addr_c; at x=IMG_W-1, rd_addr_r = rd_addr_c (edge replicate).
- rd_en = 1 exactly during the RUN cycles.
- Tag pipeline:
  - Each issued read pushes the tag {issue, x, y} into a shift register of depth MEM_LAT+DP_LAT.
  - A tag issued at cycle k emerges at cycle k+MEM_LAT+DP_LAT.
- On emergence:
  - out_valid = issue & (y >= 2).
  - out_x = x; out_y = y-1.
  - out_last = out_valid & (x == IMG_W-1) & (y == IMG_H-1).
  - Rows 0 and IMG_H-1 never produce valid results. Cross-column mixes at y=0 and y=1 are masked.
  - Valid results per frame = IMG_W*(IMG_H-2).
- busy = 1 in RUN and DRAIN; 0 in IDLE and DONE.
- start while not IDLE is ignored, with no queuing.
- abort in any state: the next state is IDLE, the tag pipeline is flushed (out_valid=0 from the next cycle), done is not pulsed, and addresses reset to 0. If abort and start arrive in the same cycle in IDLE, abort wins and the block stays IDLE.
- rst mid-scan behaves like abort and also clears done.
- The sink must accept every cycle; the datapath cannot stall, so no backpressure is supported.

Test Plan:
- IMG_W=4, IMG_H=4, start at cycle 0: rd_en high cycles 1..16 with rd_addr_c = 0,4,8,12,1,5,...,15; first out_valid at cycle 9 with (x=0, y=1); exactly 8 valid results; out_last at cycle 22 with (3,2); busy high cycles 1..22; done=1 at cycle 23 only.
- Edge clamp, IMG_W=4: at x=0,y=2: l=8, c=8, r=9; at x=3,y=1: l=6, c=7, r=7.
- Datapath and behavioural 1-cycle RAM in the bench:
  - Constant frame of 100: every valid sobel output is 0.
  - Frame pixel = 10*y: every valid output is 80.
- Abort at cycle 5 of a 4x4 scan: IDLE next cycle; rd_en=0; no out_valid after cycle 6; done never asserts. A new start afterwards gives a full clean frame.
- start pulsed at cycles 3 and 10 during a scan: ignored, and the result count is still 8. start+abort together in IDLE: busy stays 0.
- rst asserted mid-DRAIN: all outputs 0 the next cycle, state IDLE, no done.
